// File: rtl/oclib_lfsr_arb.sv
// Round-robin arbiter that shares one 33-bit XNOR LFSR (taps 33, 20) between
// several clients, issuing at most one OutWidth-bit word per cycle.
module oclib_lfsr_arb #(
    parameter int          Requesters = 4,
    parameter int          OutWidth   = 16,
    parameter logic [32:0] Seed       = 33'd1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_seed_load,
    input  logic [32:0]           i_seed_value,
    input  logic [Requesters-1:0] i_req,
    output logic [Requesters-1:0] o_grant,
    output logic [OutWidth-1:0]   o_data,
    output logic [15:0]           o_count,
    output logic                  o_seed_err
);

    localparam int          PtrW    = (Requesters > 1) ? $clog2(Requesters) : 1;
    localparam logic [32:0] Lockup  = {33{1'b1}};

    // Handshake: i_req[i] is a level request for one word per cycle; o_grant[i]
    // is a one-cycle pulse the edge after the request, and o_data is only valid
    // for the granted client while o_grant is non-zero.

    logic [32:0]           r_lfsr;
    logic [PtrW-1:0]       r_ptr;
    logic [Requesters-1:0] r_grant;
    logic [OutWidth-1:0]   r_data;
    logic [15:0]           r_count;
    logic                  r_seed_err;

    logic [32:0]           w_lfsr_d;
    logic [PtrW-1:0]       w_win;
    logic [Requesters-1:0] w_onehot;
    logic                  w_issue;

    always_comb begin
        w_lfsr_d = r_lfsr;
        for (int s = 0; s < OutWidth; s++) begin
            w_lfsr_d = {w_lfsr_d[31:0], ~(w_lfsr_d[32] ^ w_lfsr_d[19])};
        end
    end

    // Two descending passes: the second (indices above ptr) overrides the
    // first, so the lowest index after ptr wins, else the lowest at/below ptr.
    always_comb begin
        w_win = r_ptr;
        for (int i = Requesters - 1; i >= 0; i--) begin
            if (i_req[i] && (i <= int'(r_ptr))) w_win = PtrW'(i);
        end
        for (int i = Requesters - 1; i >= 0; i--) begin
            if (i_req[i] && (i > int'(r_ptr))) w_win = PtrW'(i);
        end
        w_onehot = '0;
        for (int i = 0; i < Requesters; i++) begin
            w_onehot[i] = (int'(w_win) == i);
        end
    end

    assign w_issue = i_enable && (|i_req);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr     <= Seed;
            r_ptr      <= PtrW'(Requesters - 1);
            r_grant    <= '0;
            r_data     <= '0;
            r_count    <= '0;
            r_seed_err <= 1'b0;
        end else if (i_seed_load) begin
            r_grant <= '0;
            if (i_seed_value == Lockup) begin
                r_lfsr     <= Seed;
                r_seed_err <= 1'b1;
            end else begin
                r_lfsr     <= i_seed_value;
                r_seed_err <= 1'b0;
            end
        end else if (!w_issue) begin
            r_grant <= '0;
        end else begin
            r_grant <= w_onehot;
            r_ptr   <= w_win;
            r_lfsr  <= w_lfsr_d;
            r_data  <= w_lfsr_d[OutWidth-1:0];
            r_count <= r_count + 16'd1;
        end
    end

    assign o_grant    = r_grant;
    assign o_data     = r_data;
    assign o_count    = r_count;
    assign o_seed_err = r_seed_err;

endmodule

// File: tb/tb_oclib_lfsr_arb.sv
// Directed bench for oclib_lfsr_arb: a table of per-cycle vectors plus
// hand-written sequences for reset, enable freeze and mid-burst reset.
module tb_oclib_lfsr_arb;

  localparam logic [32:0] SEED = 33'd1;
  localparam logic [32:0] ALL1 = {33{1'b1}};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        seed_load;
  logic [32:0] seed_value;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [15:0] data;
  logic [15:0] count;
  logic        seed_err;

  oclib_lfsr_arb #(.Requesters(4), .OutWidth(16), .Seed(SEED)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_seed_load  (seed_load),
    .i_seed_value (seed_value),
    .i_req        (req),
    .o_grant      (grant),
    .o_data       (data),
    .o_count      (count),
    .o_seed_err   (seed_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        en;
    logic        ld;
    logic [32:0] sv;
    logic [3:0]  req;
    logic [3:0]  g;
    logic [15:0] cnt;
    logic        err;
    logic        chk_d;
    logic [15:0] d;
  } vec_t;

  vec_t vecs[19];

  logic [32:0] m_lfsr;
  logic [15:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [32:0] advance(input logic [32:0] s);
    logic [32:0] t;
    t = s;
    for (int k = 0; k < 16; k++) t = {t[31:0], ~(t[32] ^ t[19])};
    return t;
  endfunction

  task automatic drive(input logic en, input logic ld, input logic [32:0] sv, input logic [3:0] r);
    enable = en; seed_load = ld; seed_value = sv; req = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 33'd0, 4'b0000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 33'd0, 4'b0000);
    #1;
    check("reset_grant", grant, 4'b0000);
    check("reset_data", data, 16'h0000);
    check("reset_count", count, 16'd0);
    check("reset_seed_err", seed_err, 1'b0);

    // Test 1: single request from reset yields 0xFFFF, then grant drops.
    do_reset();
    drive(1'b1, 1'b0, 33'd0, 4'b0001);
    step();
    check("t1_grant", grant, 4'b0001);
    check("t1_data", data, 16'hFFFF);
    check("t1_count", count, 16'd1);
    drive(1'b1, 1'b0, 33'd0, 4'b0000);
    step();
    check("t1_grant_drop", grant, 4'b0000);
    check("t1_count_hold", count, 16'd1);

    // Vectors: {en, ld, seed_value, req, exp grant, exp count, exp seed_err, check data, data}
    vecs[0]  = '{1'b1, 1'b0, 33'd0, 4'b1111, 4'b0001, 16'd1,  1'b0, 1'b1, 16'hFFFF};
    vecs[1]  = '{1'b1, 1'b0, 33'd0, 4'b1111, 4'b0010, 16'd2,  1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 33'd0, 4'b1111, 4'b0100, 16'd3,  1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 33'd0, 4'b1111, 4'b1000, 16'd4,  1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 33'd0, 4'b1111, 4'b0001, 16'd5,  1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 33'd0, 4'b1010, 4'b0010, 16'd6,  1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 33'd0, 4'b1010, 4'b1000, 16'd7,  1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 33'd0, 4'b1010, 4'b0010, 16'd8,  1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 33'd0, 4'b1010, 4'b1000, 16'd9,  1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 33'd1, 4'b0001, 4'b0000, 16'd9,  1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 33'd0, 4'b0001, 4'b0001, 16'd10, 1'b0, 1'b1, 16'hFFFF};
    vecs[11] = '{1'b1, 1'b0, 33'd0, 4'b0000, 4'b0000, 16'd10, 1'b0, 1'b1, 16'hFFFF};
    vecs[12] = '{1'b1, 1'b1, ALL1,  4'b0000, 4'b0000, 16'd10, 1'b1, 1'b0, 16'h0000};
    vecs[13] = '{1'b1, 1'b0, 33'd0, 4'b0100, 4'b0100, 16'd11, 1'b1, 1'b1, 16'hFFFF};
    vecs[14] = '{1'b1, 1'b1, 33'h0_1234_5678, 4'b0000, 4'b0000, 16'd11, 1'b0, 1'b0, 16'h0000};
    vecs[15] = '{1'b1, 1'b0, 33'd0, 4'b1000, 4'b1000, 16'd12, 1'b0, 1'b0, 16'h0000};
    vecs[16] = '{1'b0, 1'b0, 33'd0, 4'b1111, 4'b0000, 16'd12, 1'b0, 1'b0, 16'h0000};
    vecs[17] = '{1'b1, 1'b0, 33'd0, 4'b0100, 4'b0100, 16'd13, 1'b0, 1'b0, 16'h0000};
    vecs[18] = '{1'b1, 1'b0, 33'd0, 4'b0100, 4'b0100, 16'd14, 1'b0, 1'b0, 16'h0000};

    do_reset();
    m_lfsr = SEED;
    m_data = 16'h0000;
    for (int v = 0; v < 19; v++) begin
      drive(vecs[v].en, vecs[v].ld, vecs[v].sv, vecs[v].req);
      step();
      if (vecs[v].ld) m_lfsr = (vecs[v].sv == ALL1) ? SEED : vecs[v].sv;
      else if (vecs[v].g != 4'b0000) begin
        m_lfsr = advance(m_lfsr);
        m_data = m_lfsr[15:0];
      end
      check($sformatf("vec%0d_grant", v), grant, vecs[v].g);
      check($sformatf("vec%0d_count", v), count, vecs[v].cnt);
      check($sformatf("vec%0d_seed_err", v), seed_err, vecs[v].err);
      check($sformatf("vec%0d_data_model", v), data, m_data);
      if (vecs[v].chk_d) check($sformatf("vec%0d_data_hand", v), data, vecs[v].d);
    end

    // Test 6: enable low freezes everything, then async reset mid-burst.
    do_reset();
    drive(1'b1, 1'b0, 33'd0, 4'b0001);
    step();
    check("t6_first_data", data, 16'hFFFF);
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 33'd0, 4'b1111);
      step();
      check($sformatf("t6_dis%0d_grant", c), grant, 4'b0000);
      check($sformatf("t6_dis%0d_count", c), count, 16'd1);
      check($sformatf("t6_dis%0d_data", c), data, 16'hFFFF);
    end
    drive(1'b1, 1'b0, 33'd0, 4'b1111);
    step();
    check("t6_burst_grant", grant, 4'b0010);
    check("t6_burst_count", count, 16'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_grant", grant, 4'b0000);
    check("t6_async_data", data, 16'h0000);
    check("t6_async_count", count, 16'd0);
    check("t6_async_seed_err", seed_err, 1'b0);
    step();
    check("t6_held_grant", grant, 4'b0000);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 33'd0, 4'b1111);
    step();
    check("t6_after_grant", grant, 4'b0001);
    check("t6_after_data", data, 16'hFFFF);
    check("t6_after_count", count, 16'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
